// File: rtl/ahb_lite_req_master_if.sv
// AHB-Lite bus bundle between the request master and a single slave.
// Master drives the address/control and write data, slave returns ready/response/read data.
interface ahb_lite_req_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic              HSEL;
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic [3:0]        HPROT;
    logic [DATA_W-1:0] HWDATA;
    logic              HREADY;
    logic              HRESP;
    logic [DATA_W-1:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
        input  HREADY, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
        output HREADY, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_lite_req_master.sv
// AHB-Lite request master: a small command FIFO feeding single NONSEQ transfers
// with one address phase overlapping one outstanding data phase. One response
// pulse per command, in order. Two-cycle ERROR responses cancel the pending
// address phase, which is reissued from the FIFO head afterwards.
module ahb_lite_req_master #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [2:0]            cmd_size,
    input  logic [DATA_W-1:0]     cmd_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_write,
    output logic                  rsp_err,
    output logic [DATA_W-1:0]     rsp_rdata,
    ahb_lite_req_master_if.master bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Sizes wider than the 64-bit bus are not legal here; limit to doubleword.
    function automatic logic [2:0] clamp_size(input logic [2:0] size);
        logic [2:0] result;
        if (size > 3'd3) begin
            result = 3'd3;
        end else begin
            result = size;
        end
        return result;
    endfunction

    // Command storage (payload only; validity is tracked by the counters)
    logic              fifo_write_r [DEPTH];
    logic [ADDR_W-1:0] fifo_addr_r  [DEPTH];
    logic [2:0]        fifo_size_r  [DEPTH];
    logic [DATA_W-1:0] fifo_wdata_r [DEPTH];

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [PTR_W-1:0] rd_next_s;

    // Address phase
    logic              trans_r;
    logic [ADDR_W-1:0] haddr_r;
    logic              hwrite_r;
    logic [2:0]        hsize_r;

    // Data phase
    logic              data_active_r;
    logic              data_write_r;
    logic [DATA_W-1:0] hwdata_r;

    // Response
    logic              rsp_valid_r;
    logic              rsp_write_r;
    logic              rsp_err_r;
    logic [DATA_W-1:0] rsp_rdata_r;

    logic             push_s;
    logic             accept_s;
    logic             err_cancel_s;
    logic             complete_s;
    logic             issue_s;
    logic [PTR_W-1:0] issue_idx_s;

    assign cmd_ready    = (count_r != FULL_CNT);
    assign push_s       = cmd_valid & cmd_ready;
    assign accept_s     = trans_r & bus.HREADY;
    assign complete_s   = data_active_r & bus.HREADY;
    assign err_cancel_s = data_active_r & bus.HRESP & ~bus.HREADY;
    assign rd_next_s    = rd_ptr_r + PTR_W'(1);

    // Choose what to drive in the next address phase; only entries present
    // before this edge are eligible, so a fresh push never bypasses the FIFO.
    always_comb begin
        issue_s     = 1'b0;
        issue_idx_s = rd_ptr_r;
        if (accept_s) begin
            issue_s     = (count_r > CNT_W'(1));
            issue_idx_s = rd_next_s;
        end else if (!trans_r) begin
            issue_s     = (count_r != CNT_W'(0));
            issue_idx_s = rd_ptr_r;
        end else begin
            issue_s     = 1'b0;
            issue_idx_s = rd_ptr_r;
        end
    end

    // Write accepted commands into the storage array
    always_ff @(posedge HCLK) begin
        if (push_s) begin
            fifo_write_r[wr_ptr_r] <= cmd_write;
            fifo_addr_r[wr_ptr_r]  <= cmd_addr;
            fifo_size_r[wr_ptr_r]  <= cmd_size;
            fifo_wdata_r[wr_ptr_r] <= cmd_wdata;
        end
    end

    // FIFO pointers and occupancy; the head is popped only on address acceptance
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (accept_s) begin
                rd_ptr_r <= rd_next_s;
            end
            case ({push_s, accept_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Address phase: cancel on first ERROR cycle, advance when the slot frees, else hold
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            trans_r  <= 1'b0;
            haddr_r  <= '0;
            hwrite_r <= 1'b0;
            hsize_r  <= 3'd0;
        end else if (err_cancel_s) begin
            trans_r <= 1'b0;
        end else if (accept_s || !trans_r) begin
            trans_r <= issue_s;
            if (issue_s) begin
                haddr_r  <= fifo_addr_r[issue_idx_s];
                hwrite_r <= fifo_write_r[issue_idx_s];
                hsize_r  <= clamp_size(fifo_size_r[issue_idx_s]);
            end
        end
    end

    // Data phase: load from the accepted head, retire on HREADY
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            data_active_r <= 1'b0;
            data_write_r  <= 1'b0;
            hwdata_r      <= '0;
        end else if (accept_s) begin
            data_active_r <= 1'b1;
            data_write_r  <= hwrite_r;
            hwdata_r      <= fifo_wdata_r[rd_ptr_r];
        end else if (complete_s) begin
            data_active_r <= 1'b0;
        end
    end

    // One-cycle response pulse on each data-phase completion
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rsp_valid_r <= 1'b0;
            rsp_write_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= '0;
        end else if (complete_s) begin
            rsp_valid_r <= 1'b1;
            rsp_write_r <= data_write_r;
            rsp_err_r   <= bus.HRESP;
            rsp_rdata_r <= data_write_r ? '0 : bus.HRDATA;
        end else begin
            rsp_valid_r <= 1'b0;
            rsp_write_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= '0;
        end
    end

    assign bus.HSEL   = trans_r;
    assign bus.HTRANS = {trans_r, 1'b0};
    assign bus.HADDR  = haddr_r;
    assign bus.HWRITE = hwrite_r;
    assign bus.HSIZE  = hsize_r;
    assign bus.HBURST = 3'b000;
    assign bus.HPROT  = 4'b0011;
    assign bus.HWDATA = hwdata_r;

    assign rsp_valid = rsp_valid_r;
    assign rsp_write = rsp_write_r;
    assign rsp_err   = rsp_err_r;
    assign rsp_rdata = rsp_rdata_r;

endmodule

// File: doc/ahb_lite_req_master.md
Name: ahb_lite_req_master

Overview:
- AHB-Lite master that turns a simple valid/ready command stream into single, pipelined AHB-Lite transfers.
- Sits directly upstream of the AHB memory slave: its outputs drive the slave's HSEL/HADDR/HTRANS/HWRITE/HSIZE/HBURST/HPROT/HWDATA, and it consumes the slave's HREADYOUT/HRESP/HRDATA.
- Buffers commands in a small FIFO and returns one response per command, in order.

Parameters:
DEPTH, 4, command FIFO entries (power of two, >=2)
ADDR_W, 32, address width
DATA_W, 64, data width

Ports:
HCLK  in  1  clock
HRESETn  in  1  reset; asynchronous, active-low (one clock, HCLK)
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO not full; combinational
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  byte address
cmd_size  in  3  AHB HSIZE encoding
cmd_wdata  in  DATA_W  write data, already placed in its byte lanes
rsp_valid  out  1  one-cycle response pulse
rsp_write  out  1  echo of cmd_write
rsp_err  out  1  slave returned ERROR
rsp_rdata  out  DATA_W  HRDATA captured on read completion; 0 for writes
HSEL  out  1  equals HTRANS[1]
HADDR  out  ADDR_W  address-phase address
HTRANS  out  2  IDLE (00) or NONSEQ (10) only
HWRITE  out  1  address-phase direction
HSIZE  out  3  address-phase size; cmd_size > 3 clamped to 3
HBURST  out  3  constant 000 (SINGLE)
HPROT  out  4  constant 0011
HWDATA  out  DATA_W  data-phase write data
HREADY  in  1  slave HREADYOUT
HRESP  in  1  slave response, 1 = ERROR
HRDATA  in  DATA_W  slave read data

Behaviour:
- Reset values: HTRANS=00, HSEL=0, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, rsp_valid=0, rsp_err=0, rsp_write=0, rsp_rdata=0. FIFO is emptied, so cmd_ready=1.
- FIFO push: on cmd_valid & cmd_ready at a rising edge. cmd_ready = (count != DEPTH).
  - Push is refused when full, even if a pop occurs in the same cycle.
  - Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
- Address phase: registered.
  - If the FIFO is non-empty and the address slot is free, the head command is driven with HTRANS=10 from the next edge.
  - The slot is free when HTRANS=00, or when the current NONSEQ is accepted (HREADY=1 at the edge).
  - The head is popped when its address phase is accepted.
  - While HREADY=0, HADDR/HTRANS/HWRITE/HSIZE hold.
  - No FIFO entry -> HTRANS=00.
- Data phase: one outstanding transfer.
  - On address acceptance, the command's wdata/write/size move to data-phase registers; HWDATA is driven from there.
  - HWDATA holds while HREADY=0.
  - A data phase completes at the edge where HREADY=1.
  - rsp_valid pulses for the following cycle, with rsp_rdata = HRDATA for reads and 0 for writes.
- Pipelining: the next address phase overlaps the current data phase. Zero wait states give one transfer per cycle.
- Latency, empty bus, HREADY=1 throughout:
  - Command handshake at edge N.
  - HTRANS=10 from edge N+1, accepted at N+2.
  - Data phase completes at N+3; rsp_valid high in cycle N+3..N+4.
- ERROR (two-cycle AHB error):
  - On HRESP=1 with HREADY=0, HTRANS is forced to 00 from the next edge.
  - Any pending NONSEQ address is cancelled but not popped, so it reissues after completion.
  - Completion with HRESP=1 & HREADY=1 gives rsp_valid with rsp_err=1.
  - Subsequent commands proceed normally.
- Simultaneous push on an empty FIFO with a free slot: the command is not bypassed; its address phase starts from the next edge (latency above).
- Reset mid-transfer: all state is cleared immediately. Outstanding and buffered commands are dropped with no responses.
- No rsp backpressure: the consumer must always accept rsp_valid.

Test Plan:
- Write addr 0x0, size 3, wdata 0x1122334455667788, then read 0x0, HREADY=1 -> HTRANS=10 one cycle each; read rsp_rdata=0x1122334455667788, rsp_err=0.
- Four back-to-back writes 0x0/0x8/0x10/0x18 with zero wait -> HTRANS=10 for 4 consecutive cycles; HWDATA lags HADDR by one cycle; 4 rsp pulses on consecutive cycles.
- Read with HREADY held 0 for 2 data-phase cycles -> HADDR, HTRANS and HWDATA of the queued write stay stable; rsp_valid appears 2 cycles later than zero-wait.
- HRESP=1/HREADY=0 then HRESP=1/HREADY=1 on a read while a second command is pending -> HTRANS=00 for one cycle; rsp_err=1; second command reissued and completes with rsp_err=0.
- Hold HREADY=0 and push DEPTH+1 commands -> cmd_ready=0 after 4 pushes (one in the address slot does not free the FIFO until accepted); no overflow, all responses in order.
- Assert HRESETn=0 during a data phase -> outputs return to reset values asynchronously; no rsp_valid; cmd_ready=1 after release.
